m_main: RTL and testbench

Top-level application core of the simulation/debug board framework, instantiated by the board wrapper with in_run tied high.
- After reset it runs a fixed LED step sequence.
- Each step shows a counter on out_leds and transmits one ASCII byte on a UART TX line.
- When the sequence completes it raises out_done, which the wrapper uses to end simulation.

---
 rtl/m_main_pkg.sv | 18 +
 rtl/m_main_uart_tx.sv | 54 +++++
 rtl/m_main.sv | 97 +++++++++
 tb/tb_m_main.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/m_main_pkg.sv
// Shared types and constants for the LED/UART step sequencer.
package m_main_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [7:0] ASCII_BASE = 8'h30;
  localparam logic [7:0] LED_DONE   = 8'hFF;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/m_main_uart_tx.sv
// 8N1 UART transmitter: the start bit appears the edge after start is accepted while idle.
// A frame lasts 10*BAUD_DIV cycles; start is ignored while busy.
module uart_tx
  import m_main_pkg::*;
#(
  parameter int BAUD_DIV = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int BW = clog2_min1(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;

  // bit_cnt 0 is the start bit, 1..8 the data bits, 9 the stop bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
    end else if (!busy) begin
      if (start) begin
        busy     <= 1'b1;
        tx       <= 1'b0;
        shreg    <= {1'b1, data};
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end
    end else if (baud_cnt == BAUD_LAST) begin
      baud_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        busy <= 1'b0;
        tx   <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        tx      <= shreg[0];
        shreg   <= {1'b1, shreg[8:1]};
      end
    end else begin
      baud_cnt <= baud_cnt + BW'(1);
    end
  end

endmodule

// File: rtl/m_main.sv
// Step sequencer: shows step index on the LEDs and sends '0'+step over UART each step.
// Steps last STEP_CYCLES cycles; a step end waits for the UART to go idle.
module m_main
  import m_main_pkg::*;
#(
  parameter int NUM_STEPS   = 16,
  parameter int STEP_CYCLES = 1000,
  parameter int BAUD_DIV    = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_run,
  output logic       out_done,
  output logic [7:0] out_leds,
  output logic       out_uart_tx,
  input  logic       in_uart_rx
);

  localparam int TW = clog2_min1(STEP_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [7:0]    LAST_STEP  = 8'(NUM_STEPS - 1);

  state_t        state;
  logic [7:0]    step;
  logic [TW-1:0] timer;
  logic          step_end;
  logic          uart_start;
  logic [7:0]    uart_data;
  logic          uart_busy;
  logic          unused_rx;

  assign unused_rx = in_uart_rx;
  assign step_end  = (state == ST_RUN) && (timer == TIMER_LAST) && !uart_busy;

  // The frame launch must coincide with the step edge, so start/data are combinational.
  always_comb begin
    uart_start = 1'b0;
    uart_data  = ASCII_BASE;
    if (state == ST_IDLE && in_run) begin
      uart_start = 1'b1;
    end else if (step_end && step != LAST_STEP) begin
      uart_start = 1'b1;
      uart_data  = ASCII_BASE + step + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      step     <= '0;
      timer    <= '0;
      out_leds <= 8'h00;
      out_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_run) begin
            state    <= ST_RUN;
            step     <= '0;
            timer    <= '0;
            out_leds <= 8'h00;
          end
        end
        ST_RUN: begin
          if (step_end) begin
            timer <= '0;
            if (step != LAST_STEP) begin
              step     <= step + 8'd1;
              out_leds <= step + 8'd1;
            end else begin
              state    <= ST_DONE;
              out_done <= 1'b1;
              out_leds <= LED_DONE;
            end
          end else if (timer != TIMER_LAST) begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= ST_DONE;
        end
      endcase
    end
  end

  uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clock(clock),
    .reset(reset),
    .start(uart_start),
    .data (uart_data),
    .tx   (out_uart_tx),
    .busy (uart_busy)
  );

endmodule

// File: tb/tb_m_main.sv
// Bench for m_main: per-cycle arithmetic reference of LEDs/done/tx plus a UART byte decoder.
module tb_m_main;

  localparam int BD = 10;

  logic       clk = 1'b0;
  logic       rst, run, rx;
  logic       done, tx;
  logic [7:0] leds;
  logic       rst1, run1;
  logic       done1, tx1;
  logic [7:0] leds1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] rx_q[$];
  int         dec_t = -1;
  int         dec_i;
  logic [7:0] dec_byte;

  always #5 clk = ~clk;

  m_main #(.NUM_STEPS(16), .STEP_CYCLES(1000), .BAUD_DIV(BD)) dut (
    .clock(clk), .reset(rst), .in_run(run), .out_done(done),
    .out_leds(leds), .out_uart_tx(tx), .in_uart_rx(rx)
  );

  m_main #(.NUM_STEPS(1), .STEP_CYCLES(101), .BAUD_DIV(BD)) dut1 (
    .clock(clk), .reset(rst1), .in_run(run1), .out_done(done1),
    .out_leds(leds1), .out_uart_tx(tx1), .in_uart_rx(rx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Expected {done, leds, tx} n edges after the starting edge E0.
  function automatic logic [31:0] model(input int n, input int ns, input int sc, input int bd);
    int k, r, b;
    logic [7:0] byt;
    logic txb;
    if (n >= ns * sc) return 32'({1'b1, 8'hFF, 1'b1});
    k   = n / sc;
    r   = n % sc;
    b   = r / bd;
    byt = 8'(8'h30 + k);
    if (b == 0)      txb = 1'b0;
    else if (b <= 8) txb = byt[b-1];
    else             txb = 1'b1;
    return 32'({1'b0, 8'(k), txb});
  endfunction

  function automatic logic [31:0] outs0();
    return 32'({done, leds, tx});
  endfunction

  // Independent mid-bit UART decoder on dut's tx, one sample per cycle.
  task automatic dec_step();
    if (rst) begin
      dec_t = -1;
    end else if (dec_t < 0) begin
      if (tx === 1'b0) begin
        dec_t    = 0;
        dec_byte = 8'h00;
      end
    end else begin
      dec_t++;
      if (dec_t % BD == BD / 2) begin
        dec_i = dec_t / BD;
        if (dec_i >= 1 && dec_i <= 8) dec_byte[dec_i-1] = tx;
        else if (dec_i == 9) begin
          chk("uart_stop", 32'(tx), 32'd1);
          rx_q.push_back(dec_byte);
          dec_t = -1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    dec_step();
  endtask

  // Caller has set run=1 so the next edge is E0; in_run is randomized afterwards.
  task automatic run_check(input string tag, input int last_n);
    for (int n = 0; n <= last_n; n++) begin
      tick();
      chk(tag, outs0(), model(n, 16, 1000, BD));
      run = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_bytes(input string tag);
    logic [31:0] got;
    chk({tag, "_count"}, 32'(rx_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      got = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF;
      chk(tag, got, 32'h30 + 32'(i));
    end
  endtask

  initial begin
    int r_abort;
    rst = 1'b1; run = 1'b0; rx = 1'b1;
    rst1 = 1'b1; run1 = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outs", outs0(), 32'({1'b0, 8'h00, 1'b1}));
    end
    chk("reset_outs_1step", 32'({done1, leds1, tx1}), 32'({1'b0, 8'h00, 1'b1}));
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outs", outs0(), 32'({1'b0, 8'h00, 1'b1}));
    end

    rx_q.delete();
    run = 1'b1;
    run_check("seq", 16000);
    check_bytes("bytes");

    for (int i = 0; i < 500; i++) begin
      run = 1'($urandom_range(0, 1));
      tick();
      chk("done_hold", outs0(), 32'({1'b1, 8'hFF, 1'b1}));
    end

    rst = 1'b1; run = 1'b1;
    tick();
    chk("rerun_reset", outs0(), 32'({1'b0, 8'h00, 1'b1}));
    rst = 1'b0;
    run_check("seq_a", 2049);
    rst = 1'b1;
    tick();
    chk("mid_frame_reset", outs0(), 32'({1'b0, 8'h00, 1'b1}));
    rst = 1'b0; run = 1'b1;
    rx_q.delete();
    run_check("seq_b", 16000);
    check_bytes("bytes_rerun");

    r_abort = int'($urandom_range(1, 15999));
    rst = 1'b1; run = 1'b1;
    tick();
    rst = 1'b0;
    run_check("seq_c", r_abort - 1);
    rst = 1'b1;
    tick();
    chk("random_reset", outs0(), 32'({1'b0, 8'h00, 1'b1}));

    rst1 = 1'b0; run1 = 1'b1;
    for (int n = 0; n <= 110; n++) begin
      tick();
      chk("one_step", 32'({done1, leds1, tx1}), model(n, 1, 101, BD));
      run1 = 1'($urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
